// File: rtl/gyro_spi_pkg.sv
// Register map, CTRL reset values and FSM encoding shared by the gyro SPI responder.
// Address auto-increment is selected in the top by RESPONDER_AUTOINC_EN.
package gyro_spi_pkg;

  localparam logic [5:0] ADDR_WHO_AM_I = 6'h0F;
  localparam logic [5:0] ADDR_CTRL1    = 6'h20;
  localparam logic [5:0] ADDR_CTRL2    = 6'h21;
  localparam logic [5:0] ADDR_CTRL3    = 6'h22;
  localparam logic [5:0] ADDR_CTRL4    = 6'h23;
  localparam logic [5:0] ADDR_CTRL5    = 6'h24;
  localparam logic [5:0] ADDR_STATUS   = 6'h27;
  localparam logic [5:0] ADDR_OUT_XL   = 6'h28;
  localparam logic [5:0] ADDR_OUT_XH   = 6'h29;
  localparam logic [5:0] ADDR_OUT_YL   = 6'h2A;
  localparam logic [5:0] ADDR_OUT_YH   = 6'h2B;
  localparam logic [5:0] ADDR_OUT_ZL   = 6'h2C;
  localparam logic [5:0] ADDR_OUT_ZH   = 6'h2D;

  localparam logic [7:0] CTRL1_RST = 8'h07;
  localparam logic [7:0] CTRL2_RST = 8'h00;
  localparam logic [7:0] CTRL3_RST = 8'h00;
  localparam logic [7:0] CTRL4_RST = 8'h00;
  localparam logic [7:0] CTRL5_RST = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_READ  = 2'd2,
    ST_WRITE = 2'd3
  } spi_state_e;

  function automatic logic is_out_addr(input logic [5:0] a);
    return (a >= ADDR_OUT_XL) && (a <= ADDR_OUT_ZH);
  endfunction

  function automatic logic is_ctrl_addr(input logic [5:0] a);
    return (a >= ADDR_CTRL1) && (a <= ADDR_CTRL5);
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer with one-cycle rise/fall pulses on the synchronized level.
// Latency STAGES clk to the level, pulses one cycle later than the prior level; no backpressure.
module spi_edge_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign sync = chain[STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/gyro_spi_responder.sv
// SPI mode-3 target emulating a 3-axis gyro register file fed by fabric samples; RESPONDER_AUTOINC_EN enables ms-bit address increment.
// Inputs are oversampled (clk >= 8x sclk); OUT bytes are held stable during a burst over 0x28..0x2D and refreshed when chip_select rises.
module gyro_spi_responder
  import gyro_spi_pkg::*;
#(
  parameter logic [7:0] WHO_AM_I_VAL = 8'hD3,
  parameter int         SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        chip_select,
  input  logic        sclk,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  output logic        interrupt,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
  input  logic        sample_valid,
  output logic        busy
);

  logic cs_s, cs_rise, cs_fall;
  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic [SYNC_STAGES-1:0] mosi_chain;
  logic mosi_s;

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (chip_select),
    .sync (cs_s),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (sclk),
    .sync (sclk_level_unused),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mosi_chain <= '0;
    else      mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_s = mosi_chain[SYNC_STAGES-1];

  spi_state_e  state, state_nxt;
  logic [2:0]  bit_cnt;
  logic [7:0]  rx_shift, tx_shift, rx_byte, rd_data;
  logic [5:0]  addr, addr_adv, rd_addr;
  logic        byte_done;

  logic [7:0]  ctrl [0:4];
  logic [47:0] out_data, pend_data;
  logic        pend_vld, zyxda, zyxor;

  assign rx_byte   = {rx_shift[6:0], mosi_s};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7) && !cs_rise;
  assign busy      = (state != ST_IDLE);

`ifdef RESPONDER_AUTOINC_EN
  logic ms;
  assign addr_adv = ms ? addr + 6'd1 : addr;
`else
  assign addr_adv = addr;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cs_rise) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (cs_fall) state_nxt = ST_CMD;
        ST_CMD:  if (byte_done) state_nxt = rx_byte[7] ? ST_READ : ST_WRITE;
        default: ;
      endcase
    end
  end

  // The reload address is the freshly decoded one at the end of the command byte.
  assign rd_addr = (state == ST_CMD) ? rx_byte[5:0] : addr_adv;

  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      ADDR_WHO_AM_I: rd_data = WHO_AM_I_VAL;
      ADDR_CTRL1:    rd_data = ctrl[0];
      ADDR_CTRL2:    rd_data = ctrl[1];
      ADDR_CTRL3:    rd_data = ctrl[2];
      ADDR_CTRL4:    rd_data = ctrl[3];
      ADDR_CTRL5:    rd_data = ctrl[4];
      ADDR_STATUS:   rd_data = {zyxor, 3'b000, zyxda, 3'b000};
      ADDR_OUT_XL:   rd_data = out_data[7:0];
      ADDR_OUT_XH:   rd_data = out_data[15:8];
      ADDR_OUT_YL:   rd_data = out_data[23:16];
      ADDR_OUT_YH:   rd_data = out_data[31:24];
      ADDR_OUT_ZL:   rd_data = out_data[39:32];
      ADDR_OUT_ZH:   rd_data = out_data[47:40];
      default:       rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      addr     <= '0;
      miso     <= 1'b0;
      miso_oe  <= 1'b0;
`ifdef RESPONDER_AUTOINC_EN
      ms       <= 1'b0;
`endif
    end else begin
      miso_oe <= ~cs_s;
      if (state == ST_IDLE) begin
        if (cs_fall) bit_cnt <= '0;
      end else if (!cs_rise) begin
        if (sclk_rise) begin
          rx_shift <= rx_byte;
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            case (state)
              ST_CMD: begin
                addr <= rx_byte[5:0];
`ifdef RESPONDER_AUTOINC_EN
                ms   <= rx_byte[6];
`endif
                if (rx_byte[7]) tx_shift <= rd_data;
              end
              ST_READ: begin
                addr     <= addr_adv;
                tx_shift <= rd_data;
              end
              default: addr <= addr_adv;
            endcase
          end
        end else if (sclk_fall && state == ST_READ) begin
          miso     <= tx_shift[7];
          tx_shift <= {tx_shift[6:0], 1'b0};
        end
      end
    end
  end

  logic hold, commit, load_now, park, rd_clr, wr_en;

  // Once a sample is parked, later ones also park so the newest always wins at commit.
  assign hold     = !cs_rise && (((state == ST_READ) && is_out_addr(addr)) || pend_vld);
  assign commit   = cs_rise && pend_vld;
  assign load_now = sample_valid && !hold;
  assign park     = sample_valid && hold;
  assign rd_clr   = (state == ST_READ) && byte_done && (addr == ADDR_OUT_ZH);
  assign wr_en    = (state == ST_WRITE) && byte_done && is_ctrl_addr(addr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl[0]   <= CTRL1_RST;
      ctrl[1]   <= CTRL2_RST;
      ctrl[2]   <= CTRL3_RST;
      ctrl[3]   <= CTRL4_RST;
      ctrl[4]   <= CTRL5_RST;
      out_data  <= '0;
      pend_data <= '0;
      pend_vld  <= 1'b0;
      zyxda     <= 1'b0;
      zyxor     <= 1'b0;
      interrupt <= 1'b0;
    end else begin
      if (wr_en) begin
        case (addr)
          ADDR_CTRL1: ctrl[0] <= rx_byte;
          ADDR_CTRL2: ctrl[1] <= rx_byte;
          ADDR_CTRL3: ctrl[2] <= rx_byte;
          ADDR_CTRL4: ctrl[3] <= rx_byte;
          default:    ctrl[4] <= rx_byte;
        endcase
      end
      if (commit)   out_data <= pend_data;
      if (load_now) out_data <= {sample_z, sample_y, sample_x};
      if (park) begin
        pend_data <= {sample_z, sample_y, sample_x};
        pend_vld  <= 1'b1;
      end else if (commit) begin
        pend_vld  <= 1'b0;
      end
      if (commit || load_now) zyxda <= 1'b1;
      else if (rd_clr)        zyxda <= 1'b0;
      if (rd_clr)                                    zyxor <= 1'b0;
      else if (sample_valid && (zyxda || pend_vld)) zyxor <= 1'b1;
      interrupt <= zyxda & ctrl[2][3];
    end
  end

endmodule

// File: tb/tb_gyro_spi_responder.sv
// Randomized and directed bench for gyro_spi_responder against a transaction-level register model.
module tb_gyro_spi_responder;

  localparam int HALF = 8;
`ifdef RESPONDER_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        chip_select = 1'b1;
  logic        sclk = 1'b1;
  logic        mosi = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_x = '0, sample_y = '0, sample_z = '0;
  logic        miso, miso_oe, interrupt, busy;

  gyro_spi_responder dut (
    .clk          (clk),
    .rst          (rst),
    .chip_select  (chip_select),
    .sclk         (sclk),
    .mosi         (mosi),
    .miso         (miso),
    .miso_oe      (miso_oe),
    .interrupt    (interrupt),
    .sample_x     (sample_x),
    .sample_y     (sample_y),
    .sample_z     (sample_z),
    .sample_valid (sample_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Register-level model of the gyro
  logic [7:0]  m_ctrl [0:4];
  logic [47:0] m_out, m_pend;
  logic        m_da, m_or, m_pv;

  task automatic model_reset();
    m_ctrl[0] = 8'h07;
    for (int k = 1; k < 5; k++) m_ctrl[k] = 8'h00;
    m_out = '0; m_pend = '0; m_da = 0; m_or = 0; m_pv = 0;
  endtask

  function automatic logic [7:0] m_reg(input logic [5:0] a);
    int idx = int'(a);
    if (idx == 'h0F) return 8'hD3;
    if (idx >= 'h20 && idx <= 'h24) return m_ctrl[idx - 'h20];
    if (idx == 'h27) return {m_or, 3'b000, m_da, 3'b000};
    if (idx >= 'h28 && idx <= 'h2D) return m_out[(idx - 'h28) * 8 +: 8];
    return 8'h00;
  endfunction

  function automatic logic [5:0] m_adv(input logic [5:0] a, input logic ms);
    return a + {5'd0, ms & AUTOINC};
  endfunction

  task automatic model_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                              input logic in_win);
    if (m_da || m_pv) m_or = 1'b1;
    if (in_win || m_pv) begin
      m_pend = {z, y, x};
      m_pv   = 1'b1;
    end else begin
      m_out = {z, y, x};
      m_da  = 1'b1;
    end
  endtask

  // SPI initiator
  logic [7:0]  tx_buf [0:7];
  logic [7:0]  rx_buf [0:7];
  int          inj_bit = -1;
  int          rst_bit = -1;
  logic [15:0] inj_x, inj_y, inj_z;
  logic        oe_seen, busy_seen;

  task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    sample_x = x; sample_y = y; sample_z = z;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic spi_txn(input int nbytes, input int part_bits);
    int total = nbytes * 8 + part_bits;
    bit aborted = 0;
    chip_select = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < total; i++) begin
      sclk = 1'b0;
      mosi = tx_buf[i / 8][7 - (i % 8)];
      if (i == inj_bit) pulse_sample(inj_x, inj_y, inj_z);
      if (i == rst_bit) begin
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_miso", {31'd0, miso}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_oe", {31'd0, miso_oe}, 32'd0);
        chip_select = 1'b1;
        sclk = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (HALF) @(negedge clk);
        aborted = 1;
        break;
      end
      repeat (HALF) @(negedge clk);
      rx_buf[i / 8][7 - (i % 8)] = miso;
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    if (!aborted) begin
      repeat (HALF) @(negedge clk);
      oe_seen   = miso_oe;
      busy_seen = busy;
      chip_select = 1'b1;
      repeat (HALF + 4) @(negedge clk);
    end
  endtask

  task automatic do_read(input logic [5:0] a, input logic ms, input int n, input string tag);
    logic [5:0] ca = a;
    logic [7:0] e;
    tx_buf[0] = {1'b1, ms, a};
    for (int k = 1; k < 8; k++) tx_buf[k] = 8'($urandom);
    spi_txn(n + 1, 0);
    for (int d = 0; d < n; d++) begin
      e = m_reg(ca);
      if (inj_bit >= 8 && (inj_bit / 8 - 1) == d)
        model_sample(inj_x, inj_y, inj_z, (ca >= 6'h28) && (ca <= 6'h2D));
      check(tag, {24'd0, rx_buf[d + 1]}, {24'd0, e});
      if (ca == 6'h2D) begin
        m_da = 1'b0;
        m_or = 1'b0;
      end
      ca = m_adv(ca, ms);
    end
    if (m_pv) begin
      m_out = m_pend;
      m_da  = 1'b1;
      m_pv  = 1'b0;
    end
    inj_bit = -1;
  endtask

  task automatic do_write(input logic [5:0] a, input logic ms, input int n, input logic [7:0] d0);
    logic [5:0] ca = a;
    int idx;
    tx_buf[0] = {1'b0, ms, a};
    tx_buf[1] = d0;
    for (int k = 2; k < 8; k++) tx_buf[k] = 8'($urandom);
    spi_txn(n + 1, 0);
    for (int d = 0; d < n; d++) begin
      idx = int'(ca);
      if (idx >= 'h20 && idx <= 'h24) m_ctrl[idx - 'h20] = tx_buf[d + 1];
      ca = m_adv(ca, ms);
    end
  endtask

  task automatic run_random(input int iters);
    int op, sel, n;
    logic [5:0] a;
    logic ms;
    logic [15:0] x, y, z;
    for (int it = 0; it < iters; it++) begin
      op  = $urandom_range(0, 2);
      sel = $urandom_range(0, 3);
      ms  = 1'($urandom);
      case (sel)
        0: a = 6'h20 + 6'($urandom_range(0, 4));
        1: a = 6'h27;
        2: a = 6'h28 + 6'($urandom_range(0, 5));
        default: a = 6'($urandom);
      endcase
      case (op)
        0: begin
          n = $urandom_range(1, 2);
          do_write(a, ms, n, 8'($urandom));
        end
        1: begin
          n = $urandom_range(1, 4);
          do_read(a, ms, n, "rnd_read");
        end
        default: begin
          x = 16'($urandom); y = 16'($urandom); z = 16'($urandom);
          pulse_sample(x, y, z);
          model_sample(x, y, z, 1'b0);
          repeat (2) @(negedge clk);
        end
      endcase
      check("rnd_irq", {31'd0, interrupt}, {31'd0, m_da & m_ctrl[2][3]});
    end
  endtask

  logic [7:0] burst_exp [0:5];

  initial begin
    model_reset();
    repeat (4) @(negedge clk);
    check("reset_miso", {31'd0, miso}, 32'd0);
    check("reset_oe", {31'd0, miso_oe}, 32'd0);
    check("reset_irq", {31'd0, interrupt}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    do_read(6'h0F, 1'b0, 1, "whoami");
    check("whoami_const", {24'd0, rx_buf[1]}, 32'hD3);
    check("oe_during_cs", {31'd0, oe_seen}, 32'd1);
    check("busy_during_cs", {31'd0, busy_seen}, 32'd1);
    check("oe_after_cs", {31'd0, miso_oe}, 32'd0);
    check("busy_after_cs", {31'd0, busy}, 32'd0);

    do_write(6'h20, 1'b0, 1, 8'h0F);
    do_read(6'h20, 1'b0, 1, "ctrl1_rb");
    check("ctrl1_const", {24'd0, rx_buf[1]}, 32'h0F);
    do_write(6'h0F, 1'b0, 1, 8'h55);
    do_read(6'h0F, 1'b0, 1, "whoami_ro");
    check("whoami_ro_const", {24'd0, rx_buf[1]}, 32'hD3);

    pulse_sample(16'h1234, 16'hFEDC, 16'h8000);
    model_sample(16'h1234, 16'hFEDC, 16'h8000, 1'b0);
    repeat (2) @(negedge clk);
    do_read(6'h28, 1'b1, 6, "burst");
    if (AUTOINC) begin
      burst_exp[0] = 8'h34; burst_exp[1] = 8'h12; burst_exp[2] = 8'hDC;
      burst_exp[3] = 8'hFE; burst_exp[4] = 8'h00; burst_exp[5] = 8'h80;
    end else begin
      for (int k = 0; k < 6; k++) burst_exp[k] = 8'h34;
    end
    for (int k = 0; k < 6; k++) check("burst_const", {24'd0, rx_buf[k + 1]}, {24'd0, burst_exp[k]});

    do_write(6'h22, 1'b0, 1, 8'h08);
    do_read(6'h2D, 1'b0, 1, "clr_2d");
    pulse_sample(16'h0102, 16'h0304, 16'h0506);
    model_sample(16'h0102, 16'h0304, 16'h0506, 1'b0);
    @(negedge clk);
    check("irq_set", {31'd0, interrupt}, 32'd1);
    check("irq_model", {31'd0, interrupt}, {31'd0, m_da & m_ctrl[2][3]});
    do_read(6'h2D, 1'b0, 1, "rd_2d");
    check("irq_clr", {31'd0, interrupt}, 32'd0);

    pulse_sample(16'h1111, 16'h2222, 16'h3333);
    model_sample(16'h1111, 16'h2222, 16'h3333, 1'b0);
    pulse_sample(16'h4444, 16'h5555, 16'h6666);
    model_sample(16'h4444, 16'h5555, 16'h6666, 1'b0);
    repeat (2) @(negedge clk);
    do_read(6'h27, 1'b0, 1, "status");
    check("status_const", {24'd0, rx_buf[1]}, 32'h88);

    inj_x = 16'hA1B2; inj_y = 16'hC3D4; inj_z = 16'hE5F6;
    inj_bit = 12;
    do_read(6'h28, 1'b1, 6, "antitear_old");
    check("antitear_xl", {24'd0, rx_buf[1]}, 32'h44);
    do_read(6'h28, 1'b1, 6, "antitear_new");
    check("antitear_new_xl", {24'd0, rx_buf[1]}, 32'hB2);

    do_write(6'h21, 1'b0, 1, 8'h5A);
    tx_buf[0] = 8'h21;
    tx_buf[1] = 8'hFF;
    spi_txn(1, 4);
    do_read(6'h21, 1'b0, 1, "partial_wr");
    check("partial_const", {24'd0, rx_buf[1]}, 32'h5A);

    tx_buf[0] = 8'hE8;
    tx_buf[1] = 8'h00;
    tx_buf[2] = 8'h00;
    rst_bit = 20;
    spi_txn(3, 0);
    rst_bit = -1;
    model_reset();
    do_read(6'h20, 1'b0, 1, "post_rst_ctrl1");
    check("post_rst_const", {24'd0, rx_buf[1]}, 32'h07);
    do_read(6'h0F, 1'b0, 1, "post_rst_whoami");

    run_random(25);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
